ft_tx_arbiter: RTL
==================

# ft_tx_arbiter

Shares the single 16-bit TX write port of the FT600 245-mode bridge (`tx_en` / `tx_in` / `tx_full`) between four packet sources. It uses round-robin arbitration at packet granularity. Each granted packet is framed with a header word carrying the source ID and a trailer word carrying the data-word count, so the host can demultiplex the streams. It sits between the test/data generators and `ft600_mode245` in the `clk` domain.

## Interface
- `HDR_TAG`, 8'hA5, upper byte of the header word.
- `TRL_TAG`, 8'h5A, upper byte of the trailer word.
- `PKT_CNT_W`, 16, width of the `pkt_count` status counter.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  arbitration enable; when low, no new grant is issued.
- `req_valid`  in  4  per-source word valid.
- `req_data`  in  64  per-source data; source i uses bits [16i+15:16i].
- `req_last`  in  4  per-source last-word-of-packet flag, qualified by `req_valid`.
- `req_ready`  out  4  per-source accept.
- `tx_en`  out  1  FIFO write strobe.
- `tx_in`  out  16  FIFO write data.
- `tx_full`  in  1  FIFO full.
- `busy`  out  1  high whenever state ≠ IDLE.
- `grant`  out  2  currently or last granted source.
- `pkt_count`  out  `PKT_CNT_W`  number of packets completed; wraps.

## Operation
- **Transfer rules.**
  - A source word transfers at a rising edge when `req_valid[i] & req_ready[i]`.
  - A FIFO write occurs at a rising edge when `tx_en` is high.
  - `tx_en` and `tx_in` are combinational from state, grant and source inputs.
  - `tx_en` is never high while `tx_full` is high.
- **State machine:** IDLE, HEADER, DATA, TRAILER.
- **IDLE**
  - `req_ready` = 0, `tx_en` = 0.
  - If `en` and any `req_valid` is set, select the first valid source searching from `ptr+1` upward, mod 4.
  - Register that source into `grant`, clear `wcnt`, and go to HEADER.
  - Otherwise stay in IDLE.
- **HEADER**
  - `tx_in` = {HDR_TAG, 6'b0, grant}; `tx_en` = ~`tx_full`.
  - On a write, go to DATA.
- **DATA**
  - `req_ready[grant]` = ~`tx_full`; the other ready bits are 0.
  - `tx_en` = `req_valid[grant]` & ~`tx_full`; `tx_in` = the granted source's data slice.
  - Each write increments `wcnt` (8-bit, wraps 255→0).
  - A write with `req_last[grant]` set goes to TRAILER.
- **TRAILER**
  - `tx_in` = {TRL_TAG, count}, where count is the post-increment `wcnt` (data words in the packet, mod 256); `tx_en` = ~`tx_full`.
  - On a write: set `ptr` ← `grant`, increment `pkt_count`, and go to IDLE.
- **Boundary conditions**
  - `tx_full` high in any emitting state: hold state, all outputs stable apart from the `tx_en`/`req_ready` gating. No word is lost or duplicated.
  - Granted source drops `req_valid` mid-packet: the arbiter stalls in DATA indefinitely. There is no timeout and no preemption.
  - Other sources' `req_valid`/`req_last` are ignored until IDLE.
  - `en` falling mid-packet: the current packet completes, including its trailer; no new grant follows.
  - A packet with 256 words has trailer count 0x00 (wrap).
  - Reset mid-packet aborts without a trailer. The host discards a header that has no trailer.
- **Reset values:** state IDLE, `grant` = 0, `ptr` = 3 (source 0 wins first), `wcnt` = 0, `pkt_count` = 0, `busy` = 0, `req_ready` = 0, `tx_en` = 0, `tx_in` = 0.

## Timing
- Grant latency: the first valid request is seen in IDLE at edge k, and the header is presented in cycle k+1.
- An N-word packet with no backpressure occupies N+3 cycles: IDLE, HEADER, N×DATA, TRAILER.
- The next packet's IDLE cycle immediately follows the trailer write.
- FIFO throughput in DATA is one word per cycle while the source is valid and `tx_full` is low.
- `pkt_count` updates at the trailer-write edge and is visible the next cycle.
- `grant` changes only at the IDLE→HEADER edge.

## Test plan
- **Single packet.** Source 2 sends 3 words 0x1111/0x2222/0x3333, last on the third, `tx_full`=0. Required: FIFO sees 0xA502, 0x1111, 0x2222, 0x3333, 0x5A03 on consecutive cycles; `pkt_count`=1.
- **Round-robin.** All 4 sources continuously request 1-word packets. Required: headers appear in source order 0,1,2,3,0; no source is granted twice in a row while others are waiting.
- **Backpressure.** Hold `tx_full`=1 for 5 cycles during each of HEADER, DATA and TRAILER. Required: `tx_en`=0 and `req_ready`=0 throughout the hold; the FIFO stream is identical to the no-stall run.
- **Source stall.** Granted source 1 drops `req_valid` for 10 cycles mid-packet while source 3 requests. Required: no source-3 header is written before source 1's trailer.
- **Wrap and `en`.** A 256-word packet produces trailer 0x5A00. With `en` deasserted during DATA, the packet completes and the arbiter stays IDLE with `busy`=0 despite pending requests.
- **Reset mid-DATA.** Assert `rst` for 1 cycle mid-DATA. Required: next cycle state is IDLE, `tx_en`=0, `pkt_count`=0, and the next grant goes to source 0.

Source files
------------

// File: rtl/ft_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one 16-bit FT600 TX write port
// between four sources, framing each packet with a source-ID header and a word-count trailer.
module ft_tx_arbiter #(
    parameter logic [7:0] HDR_TAG   = 8'hA5,
    parameter logic [7:0] TRL_TAG   = 8'h5A,
    parameter int         PKT_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [3:0]           req_valid_i,
    input  logic [63:0]          req_data_i,
    input  logic [3:0]           req_last_i,
    output logic [3:0]           req_ready_o,
    output logic                 tx_en_o,
    output logic [15:0]          tx_in_o,
    input  logic                 tx_full_i,
    output logic                 busy_o,
    output logic [1:0]           grant_o,
    output logic [PKT_CNT_W-1:0] pkt_count_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        DATA    = 2'd2,
        TRAILER = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             grant_q, grant_d;
    logic [1:0]             ptr_q, ptr_d;
    logic [7:0]             wcnt_q, wcnt_d;
    logic [PKT_CNT_W-1:0]   pkt_count_q, pkt_count_d;

    logic [1:0]             next_src;
    logic [1:0]             cand;
    logic [15:0]            sel_data;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   wr;

    // Search downward so the candidate nearest to ptr+1 is the last one to win.
    always_comb begin
        next_src = ptr_q;
        cand     = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr_q + 2'(k);
            if (req_valid_i[cand]) begin
                next_src = cand;
            end
        end
    end

    assign sel_data  = req_data_i[{grant_q, 4'b0000} +: 16];
    assign sel_valid = req_valid_i[grant_q];
    assign sel_last  = req_last_i[grant_q];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        wcnt_d      = wcnt_q;
        pkt_count_d = pkt_count_q;
        req_ready_o = 4'b0000;
        wr          = 1'b0;
        tx_in_o     = 16'h0000;

        case (state_q)
            IDLE: begin
                if (en_i && (|req_valid_i)) begin
                    grant_d = next_src;
                    wcnt_d  = 8'd0;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                tx_in_o = {HDR_TAG, 6'b000000, grant_q};
                wr      = ~tx_full_i;
                if (wr) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                req_ready_o[grant_q] = ~tx_full_i;
                wr      = sel_valid & ~tx_full_i;
                tx_in_o = sel_data;
                if (wr) begin
                    wcnt_d = wcnt_q + 8'd1;
                    if (sel_last) begin
                        state_d = TRAILER;
                    end
                end
            end
            TRAILER: begin
                // wcnt already holds the post-increment count of the final data write.
                tx_in_o = {TRL_TAG, wcnt_q};
                wr      = ~tx_full_i;
                if (wr) begin
                    ptr_d       = grant_q;
                    pkt_count_d = pkt_count_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_en_o     = wr;
    assign busy_o      = (state_q != IDLE);
    assign grant_o     = grant_q;
    assign pkt_count_o = pkt_count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grant_q     <= 2'd0;
            ptr_q       <= 2'd3;
            wcnt_q      <= 8'd0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            wcnt_q      <= wcnt_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule
